// File: rtl/adc_trigger_delay.sv
`default_nettype none
// ============================================================================
//  Module      : adc_trigger_delay
//  Description : Front end of the waveform/pulse-height block. It tracks the
//                ADC baseline with a shift-based IIR filter and fires a
//                one-cycle trigger once the signal has been above
//                baseline+threshold for CONFIRM consecutive samples. A
//                42-clock holdoff follows each trigger. The raw sample
//                stream is also delayed by DELAY clocks so that the
//                downstream capture window contains pre-trigger samples.
//                Define TRIG_NEGATIVE_EN to trigger on negative-going
//                pulses instead (baseline > signal + threshold).
//  Revision    : 1.0  initial release
// ============================================================================
module adc_trigger_delay #(
  parameter int DATA_W     = 14,
  parameter int DELAY      = 6,
  parameter int CONFIRM    = 2,
  parameter int HOLDOFF    = 42,
  parameter int BASE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] signal,
  input  logic [DATA_W-1:0] threshold,
  input  logic              arm,
  output logic [DATA_W-1:0] signalDelayed,
  output logic              triggerOut,
  output logic [DATA_W-1:0] baseline,
  output logic              busy,
  output logic [15:0]       triggerCount
);

  localparam int CNT_W  = 3;
  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int BW     = DATA_W + 2;

  localparam logic [CNT_W-1:0]  CONFIRM_LAST = CNT_W'(CONFIRM);
  localparam logic [HCNT_W-1:0] HOLDOFF_LAST = HCNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_ONE     = HCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Sample delay line
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] dly_q [DELAY];
  logic [DATA_W-1:0] dly_d [DELAY];

  // Shift the new sample in at tap 0; every tap moves one stage per clock.
  always_comb begin
    dly_d[0] = signal;
    for (int i = 1; i < DELAY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // Delay-line registers, cleared so the output reads 0 until the line fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  assign signalDelayed = dly_q[DELAY-1];

  // --------------------------------------------------------------------------
  // Trigger decision state
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   baseline_q, baseline_d;
  logic [15:0]         count_q, count_d;

  logic [DATA_W:0]     over_sum;
  logic                over;
  logic signed [BW-1:0] base_err;
  logic signed [BW-1:0] base_step;
  logic signed [BW-1:0] base_sum;
  logic [DATA_W-1:0]   base_track;
  logic [CNT_W-1:0]    cnt_inc;
  logic                fire;

  // Threshold comparison; the sum carries one extra bit so it never wraps.
  always_comb begin
`ifdef TRIG_NEGATIVE_EN
    over_sum = {1'b0, signal} + {1'b0, threshold};
    over     = ({1'b0, baseline_q} > over_sum);
`else
    over_sum = {1'b0, baseline_q} + {1'b0, threshold};
    over     = ({1'b0, signal} > over_sum);
`endif
  end

  // Baseline IIR step: b + ((s - b) >>> BASE_SHIFT), clamped to the sample range.
  always_comb begin
    base_err  = $signed({2'b00, signal}) - $signed({2'b00, baseline_q});
    base_step = base_err >>> BASE_SHIFT;
    base_sum  = $signed({2'b00, baseline_q}) + base_step;
    if (base_sum[BW-1]) begin
      base_track = '0;
    end else if (base_sum[BW-2]) begin
      base_track = '1;
    end else begin
      base_track = base_sum[DATA_W-1:0];
    end
  end

  // Next-state logic for the confirm/holdoff FSM, trigger, counter and baseline.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    trig_d     = 1'b0;
    count_d    = count_q;
    valid_d    = valid_q;
    baseline_d = baseline_q;
    fire       = 1'b0;
    cnt_inc    = cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (valid_q && arm && over) begin
          if (CONFIRM_LAST == CNT_ONE) begin
            fire = 1'b1;
          end else begin
            state_d = ST_CONFIRM;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_CONFIRM: begin
        if (!over || !arm) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CONFIRM_LAST) begin
            fire = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        // arm is deliberately ignored: a started holdoff always runs out.
        if (hcnt_q == HOLDOFF_LAST) begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase

    if (fire) begin
      state_d = ST_HOLDOFF;
      hcnt_d  = '0;
      cnt_d   = '0;
      trig_d  = 1'b1;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end

    // First sample after reset seeds the baseline; afterwards only quiet
    // IDLE samples are folded in, so a candidate pulse never drags it up.
    if (!valid_q) begin
      baseline_d = signal;
      valid_d    = 1'b1;
    end else if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      baseline_d = base_track;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs; reset returns everything to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      baseline_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      baseline_q <= baseline_d;
      count_q    <= count_d;
    end
  end

  assign triggerOut   = trig_q;
  assign busy         = busy_q;
  assign baseline     = baseline_q;
  assign triggerCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_trigger_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_trigger_delay
//  Description : Directed self-checking bench for adc_trigger_delay. The
//                delayed sample stream is checked against a queue of driven
//                samples; trigger, busy, baseline and counter are checked
//                against directed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_trigger_delay;

  localparam int DATA_W = 14;
  localparam int DELAY  = 6;

  localparam logic [DATA_W-1:0] BASE = 14'd500;
`ifdef TRIG_NEGATIVE_EN
  localparam logic [DATA_W-1:0] PULSE     = 14'd300;
  localparam logic [DATA_W-1:0] NOWRAP_SIG = 14'd0;
`else
  localparam logic [DATA_W-1:0] PULSE     = 14'd700;
  localparam logic [DATA_W-1:0] NOWRAP_SIG = 14'd16383;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] signal;
  logic [DATA_W-1:0] threshold;
  logic              arm;
  logic [DATA_W-1:0] signalDelayed;
  logic              triggerOut;
  logic [DATA_W-1:0] baseline;
  logic              busy;
  logic [15:0]       triggerCount;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q [$];

  adc_trigger_delay dut (
    .clk           (clk),
    .reset         (reset),
    .signal        (signal),
    .threshold     (threshold),
    .arm           (arm),
    .signalDelayed (signalDelayed),
    .triggerOut    (triggerOut),
    .baseline      (baseline),
    .busy          (busy),
    .triggerCount  (triggerCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Delay line is empty after reset: DELAY-1 zero outputs precede the first sample.
  task automatic scb_reset();
    exp_q.delete();
    repeat (DELAY - 1) exp_q.push_back('0);
  endtask

  // One clock: record the driven sample, then compare the delayed output.
  task automatic step();
    exp_q.push_back(signal);
    @(posedge clk);
    #1;
    check("signalDelayed", signalDelayed, exp_q.pop_front());
  endtask

  // Runs from a fire edge until busy drops; holdoff must last 42 clocks.
  task automatic run_holdoff();
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    do begin
      step();
      n++;
      if (triggerOut) pulses++;
    end while (busy && n < 60);
    check("holdoff_len", n, 42);
    check("holdoff_retrig", pulses, 0);
  endtask

  initial begin
    int base_exp [8];
    int fires;
    base_exp = '{510, 519, 527, 535, 542, 549, 555, 561};

    // ---- T1: reset ----
    reset = 1'b1; signal = BASE; threshold = 14'd100; arm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", triggerOut, 0);
    check("rst_count", triggerCount, 0);
    check("rst_base", baseline, 0);
    check("rst_busy", busy, 0);
    check("rst_dly", signalDelayed, 0);
    scb_reset();
    reset = 1'b0;
    step();
    check("t1_base", baseline, 500);
    check("t1_trig", triggerOut, 0);
    check("t1_count", triggerCount, 0);
    repeat (7) step();
    check("t1_base_hold", baseline, 500);

    // ---- T2/T4: fire, holdoff, retrigger ----
    arm = 1'b1;
    signal = PULSE; step();
    check("t2_confirm_busy", busy, 1);
    check("t2_confirm_trig", triggerOut, 0);
    check("t2_confirm_base", baseline, 500);
    step();
    check("t2_fire", triggerOut, 1);
    check("t2_count", triggerCount, 1);
    check("t2_busy", busy, 1);
    for (int k = 1; k <= 44; k++) begin
      signal = (k == 1 || k == 20 || k == 21) ? PULSE : BASE;
      step();
      check("t4_holdoff_trig", triggerOut, 0);
      check("t4_holdoff_busy", busy, (k <= 41));
    end
    check("t4_count_hold", triggerCount, 1);
    check("t4_base_frozen", baseline, 500);
    signal = PULSE; step();
    check("t4_confirm2", busy, 1);
    step();
    check("t4_fire2", triggerOut, 1);
    check("t4_count2", triggerCount, 2);
    signal = BASE;
    run_holdoff();
    check("t4_base_after", baseline, 500);

    // ---- T3: glitch reject ----
    signal = PULSE; step();
    check("t3_busy", busy, 1);
    signal = BASE; step();
    check("t3_idle", busy, 0);
    check("t3_trig", triggerOut, 0);
    step();
    check("t3_base", baseline, 500);
    check("t3_count", triggerCount, 2);

    // ---- T6a: arm dropped during CONFIRM ----
    signal = PULSE; step();
    check("t6a_confirm", busy, 1);
    arm = 1'b0; step();
    check("t6a_trig", triggerOut, 0);
    check("t6a_idle", busy, 0);
    signal = BASE; step();
    check("t6a_base", baseline, 500);
    check("t6a_count", triggerCount, 2);
    arm = 1'b1;

    // ---- T5: baseline tracking ----
    threshold = 14'd200;
    signal = 14'd660;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5_track", baseline, base_exp[i]);
      check("t5_nofire", triggerOut | busy, 0);
    end
    repeat (60) step();
    check("t5_settle_up", (baseline >= 14'd645) && (baseline <= 14'd660), 1);
    check("t5_count", triggerCount, 2);
    signal = BASE;
    repeat (120) step();
    check("t5_settle_down", baseline, 500);

    // ---- T5: no-wrap at maximum threshold ----
    threshold = 14'd16383;
    signal = NOWRAP_SIG;
    fires = 0;
    repeat (8) begin
      step();
      if (triggerOut || busy) fires++;
    end
    check("t5_nowrap_fire", fires, 0);
    check("t5_nowrap_count", triggerCount, 2);

    // ---- reset and reload baseline from the next sample ----
    reset = 1'b1;
    #1;
    check("rst2_base", baseline, 0);
    check("rst2_count", triggerCount, 0);
    @(posedge clk);
    #1;
    signal = BASE; threshold = 14'd100;
    scb_reset();
    reset = 1'b0;
    step();
    check("rst2_reload", baseline, 500);
    repeat (3) step();

    // ---- T6b: asynchronous reset during HOLDOFF ----
    signal = PULSE; step(); step();
    check("t6b_fire", triggerOut, 1);
    check("t6b_count", triggerCount, 1);
    check("t6b_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6b_rst_trig", triggerOut, 0);
    check("t6b_rst_busy", busy, 0);
    check("t6b_rst_count", triggerCount, 0);
    check("t6b_rst_dly", signalDelayed, 0);
    @(posedge clk);
    #1;
    signal = BASE;
    scb_reset();
    reset = 1'b0;
    step();
    check("t6b_reload", baseline, 500);
    check("t6b_idle", busy, 0);
    repeat (2) step();
    signal = PULSE; step(); step();
    check("t6b_refire", triggerOut, 1);
    check("t6b_recount", triggerCount, 1);
    signal = BASE;
    run_holdoff();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
